ysyx_25030085_exec_ctrl: RTL and testbench
==========================================

YSYX_25030085_EXEC_CTRL -- requirements
Module: ysyx_25030085_exec_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk (input, 1, rising-edge clock) and rst (input, 1, asynchronous active-high reset).
REQ-002 The block SHALL have the following data ports:
- instruction  input  32  current RV32I instruction
- rs1_data  input  32  register-file read port 1
- rs2_data  input  32  register-file read port 2
- pc_out  output  32  current PC (registered)
- alu_result  output  32  ALU output
- imm  output  32  sign-extended immediate
REQ-003 The block SHALL have the following control outputs, all 1 bit unless a width is given:
- MemRead: load
- MemWrite: store
- RegWrite: rd write enable
- MemtoReg (2): 00 ALU, 01 memory, 10 pc+4, 11 unused
- Branch: B-type
- Jump (2): 00 sequential/branch, 01 JAL, 10 JALR
- ALUSrc: 0 selects rs2, 1 selects imm
- AluOp (4): ALU operation
- illegal_inst: undecoded opcode
REQ-004 The decoder and ALU SHALL be combinational; pc_out SHALL be the only state.

Function
REQ-005 The decoder SHALL support LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, all OP-IMM, all OP, and EBREAK (treated as a NOP with RegWrite=0).
REQ-006 imm SHALL be generated per format with bit 31 sign-extension: I [31:20]; S {[31:25],[11:7]}; B {[31],[7],[30:25],[11:8],0}; U {[31:12],12'b0}; J {[31],[19:12],[20],[30:21],0}; R-type gives 0.
REQ-007 The AluOp encoding SHALL be:
- 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR
- 0110 SRL, 0111 SRA, 1000 OR, 1001 AND
- 1010 PASSB (LUI), 1011 PCADD (pc_out+imm, AUIPC)
- others give 0
REQ-008 ALU operand A SHALL be rs1_data; operand B SHALL be imm if ALUSrc=1, else rs2_data.
REQ-009 Shift amounts SHALL use B[4:0]; SRA SHALL be arithmetic; SLT SHALL be signed; SLTU SHALL be unsigned; results SHALL be 0/1 zero-extended.
REQ-010 Arithmetic SHALL be modulo 2^32 with no overflow flag.
REQ-011 Loads, stores, JALR and OP-IMM SHALL use ADD with ALUSrc=1; OP-IMM funct7[5] SHALL select SRAI only when funct3=101.
REQ-012 OP SHALL use ALUSrc=0 with funct7[5] selecting SUB/SRA; B-type SHALL use ALUSrc=0 and AluOp=SUB.
REQ-013 RegWrite SHALL be 1 for LUI, AUIPC, JAL, JALR, loads, OP-IMM and OP.
REQ-014 MemtoReg SHALL be 10 for JAL/JALR and 01 for loads; MemRead SHALL be 1 for loads; MemWrite SHALL be 1 for stores.
REQ-015 The branch condition SHALL be evaluated internally from rs1_data/rs2_data per funct3 (EQ, NE, signed LT/GE, unsigned LTU/GEU); funct3 010/011 SHALL be not taken.
REQ-016 Next PC SHALL be:
- Jump=01: pc+imm
- Jump=10: alu_result & ~1
- Branch taken: pc+imm
- otherwise: pc+4
REQ-017 pc_out SHALL update on every rising clk edge while rst=0; PC arithmetic SHALL wrap at 2^32.
REQ-018 An unknown opcode SHALL set illegal_inst=1 with all enables 0, Jump=00, Branch=0 and imm=0; the PC SHALL advance by 4.
REQ-019 No alignment check SHALL be performed on JAL or branch targets.

Reset
REQ-020 rst=1 SHALL force pc_out=0x8000_0000 immediately, independent of clk.
REQ-021 The first rising edge after rst deasserts SHALL move pc_out to the next-PC computed from the instruction at 0x8000_0000.
REQ-022 Combinational outputs SHALL follow instruction during reset; reset asserted mid-run SHALL abandon the pending next-PC.

Verification
REQ-023 Assert rst with no clock edge -> pc_out=0x8000_0000; release rst, instruction=0x00000013, one edge -> pc_out=0x8000_0004.
REQ-024 instruction=0x00500093 (addi x1,x0,5), rs1_data=0 -> imm=5, ALUSrc=1, RegWrite=1, AluOp=0000, alu_result=5; next pc=pc+4.
REQ-025 At pc=0x8000_0004, instruction=0x010000EF (jal x1,16) -> imm=16, Jump=01, MemtoReg=10, RegWrite=1; next pc_out=0x8000_0014.
REQ-026 instruction=0x00008067 (jalr x0,0(x1)), rs1_data=0x8000_0009 -> Jump=10, alu_result=0x8000_0009; next pc_out=0x8000_0008.
REQ-027 instruction=0x12345137 (lui) -> imm=0x1234_5000, AluOp=1010, alu_result=0x1234_5000; auipc 0x00001117 at pc=0x8000_0000 -> alu_result=0x8000_1000.
REQ-028 instruction=0xFE208CE3 (beq x1,x2,-8) at pc=0x8000_0010:
- rs1_data=rs2_data=7 -> next pc_out=0x8000_0008
- rs2_data=8 -> next pc_out=0x8000_0014

Source files
------------

// File: rtl/ysyx_25030085_exec_ctrl_if.sv
// Instruction-in / decode-and-execute-out bundle for the single-cycle execute controller.
// The slave side is the controller; the master side supplies instruction and register operands.
interface ysyx_25030085_exec_ctrl_if;
    logic [31:0] instruction;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] pc_out;
    logic [31:0] alu_result;
    logic [31:0] imm;
    logic        MemRead;
    logic        MemWrite;
    logic        RegWrite;
    logic [1:0]  MemtoReg;
    logic        Branch;
    logic [1:0]  Jump;
    logic        ALUSrc;
    logic [3:0]  AluOp;
    logic        illegal_inst;

    modport master (
        output instruction, rs1_data, rs2_data,
        input  pc_out, alu_result, imm, MemRead, MemWrite, RegWrite, MemtoReg,
               Branch, Jump, ALUSrc, AluOp, illegal_inst
    );

    modport slave (
        input  instruction, rs1_data, rs2_data,
        output pc_out, alu_result, imm, MemRead, MemWrite, RegWrite, MemtoReg,
               Branch, Jump, ALUSrc, AluOp, illegal_inst
    );
endinterface

// File: rtl/ysyx_25030085_exec_ctrl.sv
// RV32I single-cycle decode, immediate generation, ALU, branch resolution and PC register.
// Only pc_out is state; everything else follows the current instruction combinationally.
module ysyx_25030085_exec_ctrl (
    input  logic                         clk,
    input  logic                         rst,
    ysyx_25030085_exec_ctrl_if.slave     bus
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_SLL   = 4'b0010;
    localparam logic [3:0] ALU_SLT   = 4'b0011;
    localparam logic [3:0] ALU_SLTU  = 4'b0100;
    localparam logic [3:0] ALU_XOR   = 4'b0101;
    localparam logic [3:0] ALU_SRL   = 4'b0110;
    localparam logic [3:0] ALU_SRA   = 4'b0111;
    localparam logic [3:0] ALU_OR    = 4'b1000;
    localparam logic [3:0] ALU_AND   = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;
    localparam logic [3:0] ALU_PCADD = 4'b1011;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic [31:0] instr_s;
    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic        funct7b5_s;
    logic [2:0]  imm_fmt_s;
    logic [31:0] imm_s;
    logic        mem_read_s;
    logic        mem_write_s;
    logic        reg_write_s;
    logic [1:0]  mem_to_reg_s;
    logic        branch_s;
    logic [1:0]  jump_s;
    logic        alu_src_s;
    logic [3:0]  alu_op_s;
    logic        illegal_s;
    logic [31:0] op_a_s;
    logic [31:0] op_b_s;
    logic [31:0] alu_result_s;
    logic        branch_cond_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] pc_plus_imm_s;
    logic [31:0] next_pc_s;
    logic [31:0] pc_r;

    // funct7[5] only means SUB when sub_en (register-register form); it always means SRA for funct3=101.
    function automatic logic [3:0] funct3_alu_op(input logic [2:0] funct3,
                                                 input logic       sub_en,
                                                 input logic       alt);
        logic [3:0] op;
        case (funct3)
            3'b000:  op = (sub_en && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    assign instr_s    = bus.instruction;
    assign opcode_s   = instr_s[6:0];
    assign funct3_s   = instr_s[14:12];
    assign funct7b5_s = instr_s[30];

    // Main decoder: control enables and immediate format per opcode.
    always_comb begin
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        reg_write_s  = 1'b0;
        mem_to_reg_s = 2'b00;
        branch_s     = 1'b0;
        jump_s       = 2'b00;
        alu_src_s    = 1'b0;
        alu_op_s     = ALU_ADD;
        illegal_s    = 1'b0;
        imm_fmt_s    = FMT_R;
        case (opcode_s)
            OPC_LUI: begin
                reg_write_s = 1'b1;
                imm_fmt_s   = FMT_U;
                alu_src_s   = 1'b1;
                alu_op_s    = ALU_PASSB;
            end
            OPC_AUIPC: begin
                reg_write_s = 1'b1;
                imm_fmt_s   = FMT_U;
                alu_src_s   = 1'b1;
                alu_op_s    = ALU_PCADD;
            end
            OPC_JAL: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 2'b10;
                jump_s       = 2'b01;
                imm_fmt_s    = FMT_J;
            end
            OPC_JALR: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 2'b10;
                jump_s       = 2'b10;
                imm_fmt_s    = FMT_I;
                alu_src_s    = 1'b1;
            end
            OPC_BRANCH: begin
                branch_s  = 1'b1;
                imm_fmt_s = FMT_B;
                alu_op_s  = ALU_SUB;
            end
            OPC_LOAD: begin
                mem_read_s   = 1'b1;
                reg_write_s  = 1'b1;
                mem_to_reg_s = 2'b01;
                imm_fmt_s    = FMT_I;
                alu_src_s    = 1'b1;
            end
            OPC_STORE: begin
                mem_write_s = 1'b1;
                imm_fmt_s   = FMT_S;
                alu_src_s   = 1'b1;
            end
            OPC_OPIMM: begin
                reg_write_s = 1'b1;
                imm_fmt_s   = FMT_I;
                alu_src_s   = 1'b1;
                alu_op_s    = funct3_alu_op(funct3_s, 1'b0, funct7b5_s);
            end
            OPC_OP: begin
                reg_write_s = 1'b1;
                alu_op_s    = funct3_alu_op(funct3_s, 1'b1, funct7b5_s);
            end
            OPC_SYSTEM: begin
                imm_fmt_s = FMT_I;
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
    end

    // Immediate assembly with bit-31 sign extension.
    always_comb begin
        case (imm_fmt_s)
            FMT_I:   imm_s = {{20{instr_s[31]}}, instr_s[31:20]};
            FMT_S:   imm_s = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
            FMT_B:   imm_s = {{19{instr_s[31]}}, instr_s[31], instr_s[7], instr_s[30:25],
                              instr_s[11:8], 1'b0};
            FMT_U:   imm_s = {instr_s[31:12], 12'h000};
            FMT_J:   imm_s = {{11{instr_s[31]}}, instr_s[31], instr_s[19:12], instr_s[20],
                              instr_s[30:21], 1'b0};
            default: imm_s = 32'h0000_0000;
        endcase
    end

    assign op_a_s        = bus.rs1_data;
    assign op_b_s        = alu_src_s ? imm_s : bus.rs2_data;
    assign pc_plus4_s    = pc_r + 32'd4;
    assign pc_plus_imm_s = pc_r + imm_s;

    // ALU datapath; all arithmetic wraps modulo 2^32.
    always_comb begin
        case (alu_op_s)
            ALU_ADD:   alu_result_s = op_a_s + op_b_s;
            ALU_SUB:   alu_result_s = op_a_s - op_b_s;
            ALU_SLL:   alu_result_s = op_a_s << op_b_s[4:0];
            ALU_SLT:   alu_result_s = {31'd0, ($signed(op_a_s) < $signed(op_b_s))};
            ALU_SLTU:  alu_result_s = {31'd0, (op_a_s < op_b_s)};
            ALU_XOR:   alu_result_s = op_a_s ^ op_b_s;
            ALU_SRL:   alu_result_s = op_a_s >> op_b_s[4:0];
            ALU_SRA:   alu_result_s = $unsigned($signed(op_a_s) >>> op_b_s[4:0]);
            ALU_OR:    alu_result_s = op_a_s | op_b_s;
            ALU_AND:   alu_result_s = op_a_s & op_b_s;
            ALU_PASSB: alu_result_s = op_b_s;
            ALU_PCADD: alu_result_s = pc_plus_imm_s;
            default:   alu_result_s = 32'h0000_0000;
        endcase
    end

    // Branch condition from the raw register operands; funct3 010/011 never take.
    always_comb begin
        case (funct3_s)
            3'b000:  branch_cond_s = (bus.rs1_data == bus.rs2_data);
            3'b001:  branch_cond_s = (bus.rs1_data != bus.rs2_data);
            3'b100:  branch_cond_s = ($signed(bus.rs1_data) <  $signed(bus.rs2_data));
            3'b101:  branch_cond_s = ($signed(bus.rs1_data) >= $signed(bus.rs2_data));
            3'b110:  branch_cond_s = (bus.rs1_data <  bus.rs2_data);
            3'b111:  branch_cond_s = (bus.rs1_data >= bus.rs2_data);
            default: branch_cond_s = 1'b0;
        endcase
    end

    // Next-PC select; JALR clears bit 0, no target alignment check anywhere.
    always_comb begin
        if (jump_s == 2'b01) begin
            next_pc_s = pc_plus_imm_s;
        end else if (jump_s == 2'b10) begin
            next_pc_s = alu_result_s & 32'hFFFF_FFFE;
        end else if (branch_s && branch_cond_s) begin
            next_pc_s = pc_plus_imm_s;
        end else begin
            next_pc_s = pc_plus4_s;
        end
    end

    // PC register; reset discards whatever next-PC was pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= next_pc_s;
        end
    end

    assign bus.pc_out       = pc_r;
    assign bus.alu_result   = alu_result_s;
    assign bus.imm          = imm_s;
    assign bus.MemRead      = mem_read_s;
    assign bus.MemWrite     = mem_write_s;
    assign bus.RegWrite     = reg_write_s;
    assign bus.MemtoReg     = mem_to_reg_s;
    assign bus.Branch       = branch_s;
    assign bus.Jump         = jump_s;
    assign bus.ALUSrc       = alu_src_s;
    assign bus.AluOp        = alu_op_s;
    assign bus.illegal_inst = illegal_s;
endmodule

// File: tb/tb_ysyx_25030085_exec_ctrl.sv
// Self-checking bench: directed scenarios plus random instruction streams checked
// against a mnemonic-level reference model of RV32I decode/execute/next-PC.
module tb_ysyx_25030085_exec_ctrl;
    logic        clk;
    logic        rst;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_pc;

    typedef struct packed {
        logic        memread;
        logic        memwrite;
        logic        regwrite;
        logic [1:0]  memtoreg;
        logic        branch;
        logic [1:0]  jump;
        logic        alusrc;
        logic [3:0]  aluop;
        logic        illegal;
        logic [31:0] imm;
        logic [31:0] alu;
        logic [31:0] npc;
        logic        chk_alu;
        logic        chk_src;
    } exp_t;

    ysyx_25030085_exec_ctrl_if bus();

    ysyx_25030085_exec_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Sign-extend the low 'bits' bits of v by arithmetic (xor/subtract trick).
    function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
        logic [31:0] m;
        m = 32'h1 << (bits - 1);
        return (v ^ m) - m;
    endfunction

    function automatic logic [3:0] code_of(input string mn);
        case (mn)
            "add":   return 4'd0;
            "sub":   return 4'd1;
            "sll":   return 4'd2;
            "slt":   return 4'd3;
            "sltu":  return 4'd4;
            "xor":   return 4'd5;
            "srl":   return 4'd6;
            "sra":   return 4'd7;
            "or":    return 4'd8;
            "and":   return 4'd9;
            "passb": return 4'd10;
            "pcadd": return 4'd11;
            default: return 4'd0;
        endcase
    endfunction

    function automatic exp_t ref_model(input logic [31:0] ins, input logic [31:0] a,
                                       input logic [31:0] b2, input logic [31:0] pc);
        exp_t        e;
        string       mn;
        string       tbl [8];
        logic [31:0] b;
        logic [2:0]  f3;
        logic        taken;
        tbl = '{"add", "sll", "slt", "sltu", "xor", "srl", "or", "and"};
        f3 = ins[14:12];
        e = '0;
        mn = "none";
        taken = 1'b0;
        e.chk_src = 1'b1;
        case (ins[6:0])
            7'h37: begin e.regwrite = 1'b1; e.imm = {ins[31:12], 12'h000}; mn = "passb"; e.alusrc = 1'b1; end
            7'h17: begin e.regwrite = 1'b1; e.imm = {ins[31:12], 12'h000}; mn = "pcadd"; e.chk_src = 1'b0; end
            7'h6f: begin
                e.regwrite = 1'b1; e.memtoreg = 2'd2; e.jump = 2'd1; e.chk_src = 1'b0;
                e.imm = sext(32'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}), 21);
            end
            7'h67: begin
                e.regwrite = 1'b1; e.memtoreg = 2'd2; e.jump = 2'd2; e.alusrc = 1'b1;
                e.imm = sext(32'(ins[31:20]), 12); mn = "add";
            end
            7'h63: begin
                e.branch = 1'b1; mn = "sub";
                e.imm = sext(32'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}), 13);
                case (f3)
                    3'd0: taken = (a == b2);
                    3'd1: taken = (a != b2);
                    3'd4: taken = ($signed(a) < $signed(b2));
                    3'd5: taken = ($signed(a) >= $signed(b2));
                    3'd6: taken = (a < b2);
                    3'd7: taken = (a >= b2);
                    default: taken = 1'b0;
                endcase
            end
            7'h03: begin
                e.memread = 1'b1; e.regwrite = 1'b1; e.memtoreg = 2'd1; e.alusrc = 1'b1;
                e.imm = sext(32'(ins[31:20]), 12); mn = "add";
            end
            7'h23: begin
                e.memwrite = 1'b1; e.alusrc = 1'b1; mn = "add";
                e.imm = sext(32'({ins[31:25], ins[11:7]}), 12);
            end
            7'h13: begin
                e.regwrite = 1'b1; e.alusrc = 1'b1; e.imm = sext(32'(ins[31:20]), 12);
                mn = (f3 == 3'd5 && ins[30]) ? "sra" : tbl[f3];
            end
            7'h33: begin
                e.regwrite = 1'b1;
                mn = (f3 == 3'd5 && ins[30]) ? "sra" : (f3 == 3'd0 && ins[30]) ? "sub" : tbl[f3];
            end
            7'h73: begin e.imm = sext(32'(ins[31:20]), 12); e.chk_src = 1'b0; end
            default: begin e.illegal = 1'b1; e.chk_src = 1'b0; end
        endcase
        e.aluop = code_of(mn);
        e.chk_alu = (mn != "none");
        b = e.alusrc ? e.imm : b2;
        case (mn)
            "add":   e.alu = a + b;
            "sub":   e.alu = a - b;
            "sll":   e.alu = a << b[4:0];
            "slt":   e.alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            "sltu":  e.alu = (a < b) ? 32'd1 : 32'd0;
            "xor":   e.alu = a ^ b;
            "srl":   e.alu = a >> b[4:0];
            "sra":   e.alu = $unsigned($signed(a) >>> b[4:0]);
            "or":    e.alu = a | b;
            "and":   e.alu = a & b;
            "passb": e.alu = e.imm;
            "pcadd": e.alu = pc + e.imm;
            default: e.alu = 32'd0;
        endcase
        if (e.jump == 2'd1 || (e.branch && taken)) e.npc = pc + e.imm;
        else if (e.jump == 2'd2) e.npc = (a + e.imm) & 32'hFFFF_FFFE;
        else e.npc = pc + 32'd4;
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        logic [2:0]  f3;
        logic [6:0]  opc;
        r = $urandom;
        f3 = r[14:12];
        case ($urandom_range(0, 11))
            0: r[6:0] = 7'h37;
            1: r[6:0] = 7'h17;
            2: r[6:0] = 7'h6f;
            3: begin r[6:0] = 7'h67; r[14:12] = 3'd0; end
            4: r[6:0] = 7'h63;
            5: begin
                r[6:0] = 7'h03; f3 = 3'($urandom_range(0, 4));
                if (f3 >= 3'd3) f3 = f3 + 3'd1;
                r[14:12] = f3;
            end
            6: begin r[6:0] = 7'h23; r[14:12] = 3'($urandom_range(0, 2)); end
            7: begin
                r[6:0] = 7'h13;
                if (f3 == 3'd1) r[31:25] = 7'd0;
                else if (f3 == 3'd5) r[31:25] = {1'b0, r[30], 5'd0};
            end
            8: begin
                r[6:0] = 7'h33;
                r[31:25] = {1'b0, (f3 == 3'd0 || f3 == 3'd5) ? r[30] : 1'b0, 5'd0};
            end
            9: r = 32'h0010_0073;
            default: begin
                do opc = 7'($urandom_range(0, 127));
                while (opc inside {7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73});
                r[6:0] = opc;
            end
        endcase
        return r;
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        bus.instruction = ins;
        bus.rs1_data    = a;
        bus.rs2_data    = b;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(32'h0050_0093, 32'd0, 32'd0);
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.pc_out !== 32'h8000_0000) begin n_err++; $display("FAIL reset_async_pc got %h exp %h", bus.pc_out, 32'h8000_0000); end
        n_cmp++; if (bus.imm !== 32'd5) begin n_err++; $display("FAIL reset_comb_imm got %h exp %h", bus.imm, 32'd5); end
        n_cmp++; if (bus.alu_result !== 32'd5) begin n_err++; $display("FAIL reset_comb_alu got %h exp %h", bus.alu_result, 32'd5); end
        @(negedge clk);
        rst = 1'b0;
        drive(32'h0000_0013, 32'd0, 32'd0);
        tick();
        n_cmp++; if (bus.pc_out !== 32'h8000_0004) begin n_err++; $display("FAIL reset_first_pc got %h exp %h", bus.pc_out, 32'h8000_0004); end
        exp_pc = 32'h8000_0004;
    endtask

    task automatic test_directed();
        drive(32'h0100_00EF, 32'd0, 32'd0);
        n_cmp++; if (bus.imm !== 32'd16) begin n_err++; $display("FAIL jal_imm got %h exp %h", bus.imm, 32'd16); end
        n_cmp++; if (bus.Jump !== 2'b01) begin n_err++; $display("FAIL jal_jump got %b exp 01", bus.Jump); end
        n_cmp++; if (bus.MemtoReg !== 2'b10) begin n_err++; $display("FAIL jal_memtoreg got %b exp 10", bus.MemtoReg); end
        n_cmp++; if (bus.RegWrite !== 1'b1) begin n_err++; $display("FAIL jal_regwrite got %b exp 1", bus.RegWrite); end
        tick();
        n_cmp++; if (bus.pc_out !== 32'h8000_0014) begin n_err++; $display("FAIL jal_pc got %h exp %h", bus.pc_out, 32'h8000_0014); end
        drive(32'h0050_0093, 32'd0, 32'd0);
        n_cmp++; if (bus.imm !== 32'd5) begin n_err++; $display("FAIL addi_imm got %h exp %h", bus.imm, 32'd5); end
        n_cmp++; if (bus.ALUSrc !== 1'b1) begin n_err++; $display("FAIL addi_alusrc got %b exp 1", bus.ALUSrc); end
        n_cmp++; if (bus.AluOp !== 4'b0000) begin n_err++; $display("FAIL addi_aluop got %b exp 0000", bus.AluOp); end
        n_cmp++; if (bus.alu_result !== 32'd5) begin n_err++; $display("FAIL addi_alu got %h exp %h", bus.alu_result, 32'd5); end
        tick();
        n_cmp++; if (bus.pc_out !== 32'h8000_0018) begin n_err++; $display("FAIL addi_pc got %h exp %h", bus.pc_out, 32'h8000_0018); end
        drive(32'h0000_8067, 32'h8000_0009, 32'd0);
        n_cmp++; if (bus.Jump !== 2'b10) begin n_err++; $display("FAIL jalr_jump got %b exp 10", bus.Jump); end
        n_cmp++; if (bus.alu_result !== 32'h8000_0009) begin n_err++; $display("FAIL jalr_alu got %h exp %h", bus.alu_result, 32'h8000_0009); end
        tick();
        n_cmp++; if (bus.pc_out !== 32'h8000_0008) begin n_err++; $display("FAIL jalr_pc got %h exp %h", bus.pc_out, 32'h8000_0008); end
        drive(32'h1234_5137, 32'hDEAD_BEEF, 32'd0);
        n_cmp++; if (bus.imm !== 32'h1234_5000) begin n_err++; $display("FAIL lui_imm got %h exp %h", bus.imm, 32'h1234_5000); end
        n_cmp++; if (bus.AluOp !== 4'b1010) begin n_err++; $display("FAIL lui_aluop got %b exp 1010", bus.AluOp); end
        n_cmp++; if (bus.alu_result !== 32'h1234_5000) begin n_err++; $display("FAIL lui_alu got %h exp %h", bus.alu_result, 32'h1234_5000); end
        tick();
        drive(32'h0000_0013, 32'd0, 32'd0);
        tick();
        n_cmp++; if (bus.pc_out !== 32'h8000_0010) begin n_err++; $display("FAIL seq_pc got %h exp %h", bus.pc_out, 32'h8000_0010); end
        drive(32'hFE20_8CE3, 32'd7, 32'd7);
        n_cmp++; if (bus.imm !== 32'hFFFF_FFF8) begin n_err++; $display("FAIL beq_imm got %h exp %h", bus.imm, 32'hFFFF_FFF8); end
        n_cmp++; if (bus.Branch !== 1'b1) begin n_err++; $display("FAIL beq_branch got %b exp 1", bus.Branch); end
        tick();
        n_cmp++; if (bus.pc_out !== 32'h8000_0008) begin n_err++; $display("FAIL beq_taken_pc got %h exp %h", bus.pc_out, 32'h8000_0008); end
        drive(32'h0000_0013, 32'd0, 32'd0);
        tick();
        tick();
        drive(32'hFE20_8CE3, 32'd7, 32'd8);
        tick();
        n_cmp++; if (bus.pc_out !== 32'h8000_0014) begin n_err++; $display("FAIL beq_not_taken_pc got %h exp %h", bus.pc_out, 32'h8000_0014); end
        exp_pc = 32'h8000_0014;
    endtask

    task automatic test_pc_wrap_illegal();
        drive(32'h0000_8067, 32'hFFFF_FFFD, 32'd0);
        tick();
        n_cmp++; if (bus.pc_out !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_jalr_pc got %h exp %h", bus.pc_out, 32'hFFFF_FFFC); end
        drive(32'h0000_0013, 32'd0, 32'd0);
        tick();
        n_cmp++; if (bus.pc_out !== 32'h0000_0000) begin n_err++; $display("FAIL wrap_up_pc got %h exp %h", bus.pc_out, 32'h0); end
        drive(32'hFE20_8CE3, 32'd3, 32'd3);
        tick();
        n_cmp++; if (bus.pc_out !== 32'hFFFF_FFF8) begin n_err++; $display("FAIL wrap_down_pc got %h exp %h", bus.pc_out, 32'hFFFF_FFF8); end
        drive(32'hFFFF_FFFF, 32'h1234_5678, 32'h8765_4321);
        n_cmp++; if (bus.illegal_inst !== 1'b1) begin n_err++; $display("FAIL illegal_flag got %b exp 1", bus.illegal_inst); end
        n_cmp++; if ({bus.MemRead, bus.MemWrite, bus.RegWrite, bus.Branch, bus.Jump} !== 5'b0) begin n_err++; $display("FAIL illegal_ctrl got %b exp 00000", {bus.MemRead, bus.MemWrite, bus.RegWrite, bus.Branch, bus.Jump}); end
        n_cmp++; if (bus.imm !== 32'd0) begin n_err++; $display("FAIL illegal_imm got %h exp 0", bus.imm); end
        tick();
        n_cmp++; if (bus.pc_out !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL illegal_pc got %h exp %h", bus.pc_out, 32'hFFFF_FFFC); end
        drive(32'h0010_0073, 32'd1, 32'd2);
        n_cmp++; if (bus.RegWrite !== 1'b0 || bus.illegal_inst !== 1'b0) begin n_err++; $display("FAIL ebreak_ctrl got rw=%b ill=%b exp 0 0", bus.RegWrite, bus.illegal_inst); end
        tick();
        n_cmp++; if (bus.pc_out !== 32'h0000_0000) begin n_err++; $display("FAIL ebreak_pc got %h exp 0", bus.pc_out); end
        exp_pc = 32'h0000_0000;
    endtask

    task automatic test_reset_midrun();
        drive(32'h0100_00EF, 32'd0, 32'd0);
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.pc_out !== 32'h8000_0000) begin n_err++; $display("FAIL midrst_pc got %h exp %h", bus.pc_out, 32'h8000_0000); end
        drive(32'h0000_1117, 32'd0, 32'd0);
        n_cmp++; if (bus.alu_result !== 32'h8000_1000) begin n_err++; $display("FAIL auipc_alu got %h exp %h", bus.alu_result, 32'h8000_1000); end
        n_cmp++; if (bus.AluOp !== 4'b1011) begin n_err++; $display("FAIL auipc_aluop got %b exp 1011", bus.AluOp); end
        tick();
        n_cmp++; if (bus.pc_out !== 32'h8000_0000) begin n_err++; $display("FAIL midrst_hold_pc got %h exp %h", bus.pc_out, 32'h8000_0000); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_cmp++; if (bus.pc_out !== 32'h8000_0004) begin n_err++; $display("FAIL midrst_release_pc got %h exp %h", bus.pc_out, 32'h8000_0004); end
        exp_pc = 32'h8000_0004;
    endtask

    task automatic test_random(input int iters);
        exp_t        e;
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < iters; i++) begin
            ins = gen_instr();
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            e = ref_model(ins, a, b, exp_pc);
            drive(ins, a, b);
            n_cmp++; if (bus.MemRead !== e.memread) begin n_err++; $display("FAIL rnd%0d_memread ins=%h got %b exp %b", i, ins, bus.MemRead, e.memread); end
            n_cmp++; if (bus.MemWrite !== e.memwrite) begin n_err++; $display("FAIL rnd%0d_memwrite ins=%h got %b exp %b", i, ins, bus.MemWrite, e.memwrite); end
            n_cmp++; if (bus.RegWrite !== e.regwrite) begin n_err++; $display("FAIL rnd%0d_regwrite ins=%h got %b exp %b", i, ins, bus.RegWrite, e.regwrite); end
            n_cmp++; if (bus.MemtoReg !== e.memtoreg) begin n_err++; $display("FAIL rnd%0d_memtoreg ins=%h got %b exp %b", i, ins, bus.MemtoReg, e.memtoreg); end
            n_cmp++; if (bus.Branch !== e.branch) begin n_err++; $display("FAIL rnd%0d_branch ins=%h got %b exp %b", i, ins, bus.Branch, e.branch); end
            n_cmp++; if (bus.Jump !== e.jump) begin n_err++; $display("FAIL rnd%0d_jump ins=%h got %b exp %b", i, ins, bus.Jump, e.jump); end
            n_cmp++; if (bus.illegal_inst !== e.illegal) begin n_err++; $display("FAIL rnd%0d_illegal ins=%h got %b exp %b", i, ins, bus.illegal_inst, e.illegal); end
            n_cmp++; if (bus.imm !== e.imm) begin n_err++; $display("FAIL rnd%0d_imm ins=%h got %h exp %h", i, ins, bus.imm, e.imm); end
            if (e.chk_src) begin
                n_cmp++; if (bus.ALUSrc !== e.alusrc) begin n_err++; $display("FAIL rnd%0d_alusrc ins=%h got %b exp %b", i, ins, bus.ALUSrc, e.alusrc); end
            end
            if (e.chk_alu) begin
                n_cmp++; if (bus.AluOp !== e.aluop) begin n_err++; $display("FAIL rnd%0d_aluop ins=%h got %b exp %b", i, ins, bus.AluOp, e.aluop); end
                n_cmp++; if (bus.alu_result !== e.alu) begin n_err++; $display("FAIL rnd%0d_alu ins=%h a=%h b=%h got %h exp %h", i, ins, a, b, bus.alu_result, e.alu); end
            end
            tick();
            n_cmp++; if (bus.pc_out !== e.npc) begin n_err++; $display("FAIL rnd%0d_pc ins=%h a=%h b=%h got %h exp %h", i, ins, a, b, bus.pc_out, e.npc); end
            exp_pc = e.npc;
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.instruction = 32'h0000_0013;
        bus.rs1_data    = 32'd0;
        bus.rs2_data    = 32'd0;
        exp_pc          = 32'h8000_0000;
        test_reset();
        test_directed();
        test_pc_wrap_illegal();
        test_reset_midrun();
        test_random(600);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
